// File: rtl/audio_pkg.sv
// Shared audio definitions: transmitter FSM states and I2S framing constants.
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } tx_state_e;

    localparam int unsigned I2S_CHANNELS     = 2;
    localparam int unsigned I2S_SLOT_MAX     = 32;
    localparam int unsigned I2S_BCLK_DIV_MIN = 2;
    localparam logic        I2S_WS_LEFT      = 1'b0;
    localparam logic        I2S_WS_RIGHT     = 1'b1;

endpackage

// File: rtl/audio_clk_div.sv
// BCLK generator: counts BCLK_DIV clks per half period and flags each BCLK edge.
module audio_clk_div #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic rise_ev,
    output logic fall_ev,
    output logic bclk
);
    localparam int unsigned   CW       = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(BCLK_DIV - 1);

    logic [CW-1:0] div_cnt_q;
    logic          bclk_q;
    logic          rise_next_q;
    logic          wrap_c;

    // The first wrap after enabling is a falling event with bclk already low.
    assign wrap_c  = en && (div_cnt_q == DIV_LAST);
    assign rise_ev = wrap_c && rise_next_q;
    assign fall_ev = wrap_c && !rise_next_q;
    assign bclk    = bclk_q;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt_q   <= '0;
            bclk_q      <= 1'b0;
            rise_next_q <= 1'b0;
        end else if (wrap_c) begin
            div_cnt_q   <= '0;
            bclk_q      <= rise_next_q;
            rise_next_q <= !rise_next_q;
        end else begin
            div_cnt_q   <= div_cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/bhg_audio_i2s_tx.sv
// I2S transmitter: serialises one stereo pair per frame and requests the next pair from the mixer.
module bhg_audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int unsigned IN_BITS   = 12,
    parameter int unsigned SLOT_BITS = 16,
    parameter int unsigned BCLK_DIV  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tx_en,
    input  logic signed [IN_BITS-1:0] s_in_l,
    input  logic signed [IN_BITS-1:0] s_in_r,
    output logic                      sample_req,
    output logic                      i2s_bclk,
    output logic                      i2s_lrclk,
    output logic                      i2s_sdata,
    output logic                      busy
);
    localparam int unsigned   FRAME_BITS = I2S_CHANNELS * SLOT_BITS;
    localparam int unsigned   BW         = $clog2(FRAME_BITS);
    localparam int unsigned   PAD_BITS   = SLOT_BITS - IN_BITS;
    localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] SLOT_LAST  = BW'(SLOT_BITS - 1);

    if (IN_BITS < 1 || IN_BITS > SLOT_BITS || SLOT_BITS > I2S_SLOT_MAX ||
        BCLK_DIV < I2S_BCLK_DIV_MIN) begin : g_param_err
        $error("bhg_audio_i2s_tx: parameter out of range");
    end

    tx_state_e            state_q;
    logic [BW-1:0]        bit_cnt_q;
    logic                 started_q;
    logic [FRAME_BITS-1:0] shreg_q;
    logic                 lrclk_q;
    logic                 sdata_q;
    logic                 req_q;
    logic                 busy_q;

    logic                 rise_ev_c;
    logic                 fall_ev_c;
    logic                 frame_end_c;
    logic                 frame_start_c;
    logic [SLOT_BITS-1:0] slot_l_c;
    logic [SLOT_BITS-1:0] slot_r_c;

    audio_clk_div #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clk_div (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q != ST_IDLE),
        .rise_ev (rise_ev_c),
        .fall_ev (fall_ev_c),
        .bclk    (i2s_bclk)
    );

    // Samples sit MSB-aligned in their slot, zero padded below.
    assign slot_l_c      = SLOT_BITS'($unsigned(s_in_l)) << PAD_BITS;
    assign slot_r_c      = SLOT_BITS'($unsigned(s_in_r)) << PAD_BITS;
    assign frame_end_c   = started_q && (bit_cnt_q == BIT_LAST);
    assign frame_start_c = !started_q || frame_end_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            started_q <= 1'b0;
            shreg_q   <= '0;
            lrclk_q   <= 1'b0;
            sdata_q   <= 1'b0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            req_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tx_en) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN:   if (!tx_en) state_q <= ST_DRAIN;
                ST_DRAIN: if (tx_en)  state_q <= ST_RUN;
                default:  state_q <= ST_IDLE;
            endcase

            if (fall_ev_c) begin
                if (frame_end_c && state_q == ST_DRAIN && !tx_en) begin
                    state_q   <= ST_IDLE;
                    bit_cnt_q <= '0;
                    started_q <= 1'b0;
                    shreg_q   <= '0;
                    lrclk_q   <= 1'b0;
                    sdata_q   <= 1'b0;
                    busy_q    <= 1'b0;
                end else begin
                    // The bit leaving the MSB is one BCLK behind its slot, giving I2S delay.
                    sdata_q <= shreg_q[FRAME_BITS-1];
                    if (frame_start_c) begin
                        bit_cnt_q <= '0;
                        started_q <= 1'b1;
                        shreg_q   <= {slot_l_c, slot_r_c};
                        req_q     <= 1'b1;
                        lrclk_q   <= I2S_WS_LEFT;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                        shreg_q   <= shreg_q << 1;
                        lrclk_q   <= (bit_cnt_q >= SLOT_LAST) ? I2S_WS_RIGHT : I2S_WS_LEFT;
                    end
                end
            end
        end
    end

    a_edge_exclusive: assert property (@(posedge clk) disable iff (rst) !(rise_ev_c && fall_ev_c));

    assign sample_req = req_q;
    assign i2s_lrclk  = lrclk_q;
    assign i2s_sdata  = sdata_q;
    assign busy       = busy_q;

endmodule
